// File: rtl/vec_issue_sched.sv
// ID-stage issue scheduler: steps a vector op one element per cycle into ID/EXE,
// inserts a one-cycle load-use bubble from IDLE, and flushes on a taken branch.
module vec_issue_sched #(
    parameter int VLEN  = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_vec,
    input  logic [CNT_W-1:0] id_vlen_m1,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             exe_memread,
    input  logic [4:0]       exe_rt_addr,
    input  logic             branch_taken,
    output logic [1:0]       next_state,
    output logic [CNT_W-1:0] cnt_o,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idexe_bubble,
    output logic             vec_busy,
    output logic             elem_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VRUN = 2'd1,
        HAZ  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VLEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] vlen_q, vlen_d;
    logic [CNT_W-1:0] m1;
    logic             hz;

    assign m1 = (id_vlen_m1 > LAST_IDX) ? LAST_IDX : id_vlen_m1;

    assign hz = id_valid & exe_memread & (exe_rt_addr != 5'd0) &
                ((exe_rt_addr == id_rs_addr) | (exe_rt_addr == id_rt_addr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vlen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vlen_q  <= vlen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vlen_d       = vlen_q;
        cnt_o        = '0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idexe_bubble = 1'b0;
        elem_last    = 1'b0;

        if (branch_taken) begin
            idexe_bubble = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else begin
            case (state_q)
                VRUN: begin
                    cnt_o = cnt_q;
                    if (cnt_q != vlen_q) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                    end else begin
                        elem_last = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    // HAZ decodes like IDLE but never re-enters itself: the bubble is one cycle.
                    if (hz && (state_q == IDLE)) begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idexe_bubble = 1'b1;
                        state_d      = HAZ;
                    end else if (id_valid && id_is_vec) begin
                        if (m1 == '0) begin
                            elem_last = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            vlen_d     = m1;
                            cnt_d      = CNT_W'(1);
                            state_d    = VRUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    assign next_state = state_d;
    assign vec_busy   = (state_q == VRUN);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == VRUN) |-> (cnt_q <= vlen_q));
    a_bubble_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(idexe_bubble && elem_last));

endmodule

// File: tb/tb_vec_issue_sched.sv
// Scoreboard bench for vec_issue_sched: directed scenarios then randomized traffic
// checked against a per-instruction reference model.
module tb_vec_issue_sched;

    localparam int VLEN  = 8;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic             id_is_vec = 1'b0;
    logic [CNT_W-1:0] id_vlen_m1 = '0;
    logic [4:0]       id_rs_addr = '0;
    logic [4:0]       id_rt_addr = '0;
    logic             exe_memread = 1'b0;
    logic [4:0]       exe_rt_addr = '0;
    logic             branch_taken = 1'b0;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt_o;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idexe_bubble;
    logic             vec_busy;
    logic             elem_last;

    always #5 clk = ~clk;

    vec_issue_sched #(.VLEN(VLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_is_vec    (id_is_vec),
        .id_vlen_m1   (id_vlen_m1),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .exe_memread  (exe_memread),
        .exe_rt_addr  (exe_rt_addr),
        .branch_taken (branch_taken),
        .next_state   (next_state),
        .cnt_o        (cnt_o),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idexe_bubble (idexe_bubble),
        .vec_busy     (vec_busy),
        .elem_last    (elem_last)
    );

    typedef struct packed {
        bit               chk;
        logic [1:0]       ns;
        logic [CNT_W-1:0] cnt;
        bit               pcs;
        bit               ifs;
        bit               bub;
        bit               busy;
        bit               last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: index of the element due next (-1 when no vector op is
    // in flight), the op's last index, and whether last cycle was a load-use bubble.
    int m_idx = -1;
    int m_last = 0;
    bit m_haz = 1'b0;

    task automatic step(input bit rstn, input bit v, input bit isv, input int m1,
                        input logic [4:0] rs, input logic [4:0] rt, input bit mr,
                        input logic [4:0] ert, input bit br);
        exp_t e;
        int   mm;
        bit   hzc;
        @(posedge clk);
        #1;
        // After a bubble the load has left EXE, so no load is presented then.
        if (m_haz) mr = 1'b0;
        rst_n        = rstn;
        id_valid     = v;
        id_is_vec    = isv;
        id_vlen_m1   = CNT_W'(m1);
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        exe_memread  = mr;
        exe_rt_addr  = ert;
        branch_taken = br;
        e = '0;
        e.chk = rstn;
        if (!rstn) begin
            m_idx = -1;
            m_haz = 1'b0;
        end else if (m_idx >= 0) begin
            e.busy = 1'b1;
            m_haz  = 1'b0;
            if (br) begin
                e.bub = 1'b1;
                e.ns  = 2'd0;
                m_idx = -1;
            end else begin
                e.cnt = CNT_W'(m_idx);
                if (m_idx == m_last) begin
                    e.last = 1'b1;
                    e.ns   = 2'd0;
                    m_idx  = -1;
                end else begin
                    e.pcs = 1'b1;
                    e.ifs = 1'b1;
                    e.ns  = 2'd1;
                    m_idx = m_idx + 1;
                end
            end
        end else begin
            hzc = v && mr && (ert != 0) && ((ert == rs) || (ert == rt));
            if (br) begin
                e.bub = 1'b1;
                e.ns  = 2'd0;
                m_haz = 1'b0;
            end else if (hzc) begin
                e.pcs = 1'b1;
                e.ifs = 1'b1;
                e.bub = 1'b1;
                e.ns  = 2'd2;
                m_haz = 1'b1;
            end else begin
                m_haz = 1'b0;
                e.ns  = 2'd0;
                if (v && isv) begin
                    mm = (m1 % 32 > VLEN - 1) ? VLEN - 1 : m1 % 32;
                    if (mm == 0) begin
                        e.last = 1'b1;
                    end else begin
                        e.pcs  = 1'b1;
                        e.ifs  = 1'b1;
                        e.ns   = 2'd1;
                        m_idx  = 1;
                        m_last = mm;
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic idle_cyc();
        step(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic scalar_cyc();
        step(1, 1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0);
    endtask

    task automatic vec_cycles(input int m1, input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, m1, 5'd3, 5'd4, 0, 5'd0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    chk("next_state",   32'(next_state),   32'(e.ns));
                    chk("cnt_o",        32'(cnt_o),        32'(e.cnt));
                    chk("pc_stall",     32'(pc_stall),     32'(e.pcs));
                    chk("ifid_stall",   32'(ifid_stall),   32'(e.ifs));
                    chk("idexe_bubble", 32'(idexe_bubble), 32'(e.bub));
                    chk("vec_busy",     32'(vec_busy),     32'(e.busy));
                    chk("elem_last",    32'(elem_last),    32'(e.last));
                end
            end
        end
    end

    initial begin : stimulus
        step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        idle_cyc();

        vec_cycles(3, 4);
        scalar_cyc();

        vec_cycles(0, 1);
        scalar_cyc();

        step(1, 1, 0, 0, 5'd5, 5'd1, 1, 5'd5, 0);
        step(1, 1, 0, 0, 5'd5, 5'd1, 1, 5'd5, 0);
        step(1, 1, 0, 0, 5'd5, 5'd1, 1, 5'd0, 0);
        step(1, 1, 1, 2, 5'd2, 5'd7, 1, 5'd7, 0);
        step(1, 1, 1, 2, 5'd2, 5'd7, 1, 5'd7, 0);
        vec_cycles(2, 2);
        idle_cyc();

        vec_cycles(6, 2);
        step(1, 1, 1, 6, 5'd3, 5'd4, 0, 5'd0, 1);
        idle_cyc();

        vec_cycles(20, 8);
        scalar_cyc();

        vec_cycles(6, 4);
        step(0, 1, 1, 6, 5'd3, 5'd4, 0, 5'd0, 0);
        step(0, 1, 1, 6, 5'd3, 5'd4, 0, 5'd0, 0);
        idle_cyc();
        scalar_cyc();

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) != 0,
                 $urandom_range(3) != 0,
                 $urandom_range(1) == 1,
                 ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(9)),
                 5'($urandom_range(3)),
                 5'($urandom_range(3)),
                 $urandom_range(2) == 0,
                 5'($urandom_range(3)),
                 $urandom_range(15) == 0);
        end
        idle_cyc();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_issue_sched.md
Name: vec_issue_sched

Overview:
- Issue scheduler for the ID stage of the vector pipeline.
- Sequences multi-element vector instructions: holds the instruction in ID and issues one element per cycle into the ID/EXE register. Drives that register's state and element-count inputs (next_state, cnt_i).
- Inserts a one-cycle bubble on a load-use hazard.
- Flushes on a taken branch.

Parameters:
- VLEN, 8, maximum elements per vector instruction (1..32).
- CNT_W, 5, element counter width; must satisfy 2^CNT_W >= VLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a valid instruction
- id_is_vec  in  1  ID instruction is a vector op
- id_vlen_m1  in  CNT_W  last element index of the ID vector op
- id_rs_addr  in  5  ID source register 1
- id_rt_addr  in  5  ID source register 2
- exe_memread  in  1  EXE instruction is a load
- exe_rt_addr  in  5  EXE load destination
- branch_taken  in  1  branch resolved taken this cycle
- next_state  out  2  scheduler state to ID/EXE (0 IDLE, 1 VRUN, 2 HAZ)
- cnt_o  out  CNT_W  element index issued this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idexe_bubble  out  1  zero ID/EXE control signals (RegWrite, VRegWrite, write=1 inactive, branch)
- vec_busy  out  1  vector op in progress (state==VRUN)
- elem_last  out  1  last element of a vector op issues this cycle

Behaviour:
- Registers:
  - state: 2 bits, reset IDLE.
  - cnt: CNT_W bits, reset 0.
  - vlen_reg: CNT_W bits, reset 0.
  - All update on posedge clk. rst_n low at an edge clears them regardless of other inputs, including mid-vector; there is no resumption.
- Outputs are combinational from registers and inputs.
- Immediately after reset (IDLE, inputs low), every output is 0.
- m1 = min(id_vlen_m1, VLEN-1). Any larger value is clamped.
- hz = id_valid & exe_memread & (exe_rt_addr!=0) & (exe_rt_addr==id_rs_addr | exe_rt_addr==id_rt_addr).
- Priority in every state: branch_taken > hz > vector issue.
- branch_taken (any state):
  - idexe_bubble=1, stalls=0, cnt_o=0.
  - Next state IDLE, cnt<=0.
  - Aborts a vector op mid-sequence.
- IDLE or HAZ, no branch:
  - If hz: pc_stall=ifid_stall=idexe_bubble=1, next state HAZ.
  - HAZ is only entered from IDLE. Hazard checking is not performed in VRUN.
  - Else if id_valid & id_is_vec:
    - Element 0 issues, cnt_o=0.
    - If m1==0: elem_last=1, no stall, stay IDLE.
    - Else: pc_stall=ifid_stall=1, vlen_reg<=m1, cnt<=1, next VRUN.
  - Else: scalar or empty issue, no stall, next IDLE.
  - HAZ lasts exactly one cycle. Its decode is identical to IDLE; the re-presented instruction issues there.
- VRUN, no branch:
  - cnt_o=cnt.
  - If cnt != vlen_reg: pc_stall=ifid_stall=1, cnt<=cnt+1, stay VRUN.
  - If cnt == vlen_reg: elem_last=1, stalls=0, cnt<=0, next IDLE.
  - The instruction after the vector op enters ID on the following edge. Issue is back-to-back with no dead cycle.
- next_state output = the state register value to be loaded this edge (the D input).
- A vector op with m1=k occupies exactly k+1 issue cycles.
- The counter never exceeds vlen_reg and never wraps.
- idexe_bubble is never asserted together with a valid element issue.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while a vector op is mid-VRUN with cnt=3 -> after release state=IDLE, cnt_o=0, all stalls 0.
- Vector op id_vlen_m1=3 -> cnt_o sequence 0,1,2,3; stalls=1,1,1,0; elem_last only on cnt_o=3; a scalar issues on the next cycle.
- Single-element vector (id_vlen_m1=0) followed by a scalar -> no stall, elem_last=1 for one cycle, state stays IDLE.
- Load-use: exe_memread=1, exe_rt_addr=5, id_rs_addr=5 -> one cycle with pc_stall=ifid_stall=idexe_bubble=1, next_state=2; following cycle the instruction issues. Repeat with exe_rt_addr=0 -> no stall.
- branch_taken at cnt_o=2 of an id_vlen_m1=6 op -> idexe_bubble=1, next cycle IDLE, cnt_o=0, vec_busy=0.
- Clamp: VLEN=8, id_vlen_m1=20 -> exactly 8 elements (cnt_o 0..7), elem_last at 7.
